// File: rtl/demux3_64bit_reg_if.sv
// Bus bundle for the registered 1-to-3 result router: one input port and three buffered channels.
// The err_cnt signal exists only when DEMUX3_ERR_CNT_EN is defined.
interface demux3_64bit_reg_if #(
  parameter int WIDTH = 64
);
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic             in_valid;
  logic             in_ready;

  logic [WIDTH-1:0] y0;
  logic [WIDTH-1:0] y1;
  logic [WIDTH-1:0] y2;
  logic             y0_valid;
  logic             y1_valid;
  logic             y2_valid;
  logic             y0_ready;
  logic             y1_ready;
  logic             y2_ready;

  logic             sel_err;
`ifdef DEMUX3_ERR_CNT_EN
  logic [15:0]      err_cnt;
`endif

  // The master drives the input word and the consumer readies; the router is the slave.
  modport master (
    output in_data, in_sel, in_valid, y0_ready, y1_ready, y2_ready,
    input  in_ready, y0, y1, y2, y0_valid, y1_valid, y2_valid, sel_err
`ifdef DEMUX3_ERR_CNT_EN
    , input err_cnt
`endif
  );

  modport slave (
    input  in_data, in_sel, in_valid, y0_ready, y1_ready, y2_ready,
    output in_ready, y0, y1, y2, y0_valid, y1_valid, y2_valid, sel_err
`ifdef DEMUX3_ERR_CNT_EN
    , output err_cnt
`endif
  );
endinterface

// File: rtl/demux3_64bit_reg.sv
// Registered 1-to-3 result router with a one-entry buffer per channel.
// Optional saturating invalid-select counter enabled by DEMUX3_ERR_CNT_EN.
module demux3_64bit_reg #(
  parameter int WIDTH = 64
) (
  input logic               clk,
  input logic               reset,
  demux3_64bit_reg_if.slave bus
);

  logic [WIDTH-1:0] y_q [3];
  logic [WIDTH-1:0] y_d [3];
  logic [2:0]       y_valid_q;
  logic [2:0]       y_valid_d;
  logic             sel_err_q;
  logic             sel_err_d;
  logic [2:0]       y_ready;
  logic             in_ready_c;
  logic             accept;
`ifdef DEMUX3_ERR_CNT_EN
  logic [15:0]      err_cnt_q;
  logic [15:0]      err_cnt_d;
`endif

  assign y_ready = {bus.y2_ready, bus.y1_ready, bus.y0_ready};

  // A channel can take a word when empty or when its current word drains this cycle.
  always_comb begin
    in_ready_c = 1'b1;
    case (bus.in_sel)
      2'b00:   in_ready_c = !y_valid_q[0] | y_ready[0];
      2'b01:   in_ready_c = !y_valid_q[1] | y_ready[1];
      2'b10:   in_ready_c = !y_valid_q[2] | y_ready[2];
      default: in_ready_c = 1'b1;
    endcase
  end

  assign accept = bus.in_valid & in_ready_c;

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      y_d[k]       = y_q[k];
      y_valid_d[k] = y_valid_q[k] & ~y_ready[k];
      if (accept && bus.in_sel == 2'(k)) begin
        y_d[k]       = bus.in_data;
        y_valid_d[k] = 1'b1;
      end
    end
    sel_err_d = accept && bus.in_sel == 2'b11;
`ifdef DEMUX3_ERR_CNT_EN
    err_cnt_d = err_cnt_q;
    if (sel_err_d && err_cnt_q != 16'hFFFF) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 3; k++) begin
        y_q[k] <= '0;
      end
      y_valid_q <= '0;
      sel_err_q <= 1'b0;
`ifdef DEMUX3_ERR_CNT_EN
      err_cnt_q <= '0;
`endif
    end else begin
      for (int k = 0; k < 3; k++) begin
        y_q[k] <= y_d[k];
      end
      y_valid_q <= y_valid_d;
      sel_err_q <= sel_err_d;
`ifdef DEMUX3_ERR_CNT_EN
      err_cnt_q <= err_cnt_d;
`endif
    end
  end

  assign bus.in_ready = in_ready_c;
  assign bus.y0       = y_q[0];
  assign bus.y1       = y_q[1];
  assign bus.y2       = y_q[2];
  assign bus.y0_valid = y_valid_q[0];
  assign bus.y1_valid = y_valid_q[1];
  assign bus.y2_valid = y_valid_q[2];
  assign bus.sel_err  = sel_err_q;
`ifdef DEMUX3_ERR_CNT_EN
  assign bus.err_cnt  = err_cnt_q;
`endif

endmodule

// File: tb/tb_demux3_64bit_reg.sv
// Directed self-checking bench for demux3_64bit_reg; checks err_cnt when DEMUX3_ERR_CNT_EN is defined.
module tb_demux3_64bit_reg;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  demux3_64bit_reg_if #(.WIDTH(64)) bus ();

  demux3_64bit_reg #(.WIDTH(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [1:0] sel, input logic [63:0] data,
                               input logic r0, input logic r1, input logic r2);
    bus.in_valid = valid;
    bus.in_sel   = sel;
    bus.in_data  = data;
    bus.y0_ready = r0;
    bus.y1_ready = r1;
    bus.y2_ready = r2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkValids(input string tag, input logic v0, input logic v1, input logic v2);
    checkOutput({tag, "_v0"}, 64'(bus.y0_valid), 64'(v0));
    checkOutput({tag, "_v1"}, 64'(bus.y1_valid), 64'(v1));
    checkOutput({tag, "_v2"}, 64'(bus.y2_valid), 64'(v2));
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 2'b00, 64'd0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    reset = 1'b0;
    checkValids("rst", 1'b0, 1'b0, 1'b0);
    checkOutput("rst_y0", bus.y0, 64'd0);
    checkOutput("rst_sel_err", 64'(bus.sel_err), 64'd0);

    // Single word to ch1, drained on the following cycle.
    applyStimulus(1'b1, 2'b01, 64'd120, 1'b1, 1'b1, 1'b1);
    #1 checkOutput("t1_in_ready", 64'(bus.in_ready), 64'd1);
    step();
    checkOutput("t1_y1", bus.y1, 64'd120);
    checkValids("t1_fill", 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 2'b00, 64'd0, 1'b1, 1'b1, 1'b1);
    step();
    checkValids("t1_drain", 1'b0, 1'b0, 1'b0);
    checkOutput("t1_y1_keep", bus.y1, 64'd120);

    // Backpressure on ch0, then simultaneous drain and fill.
    applyStimulus(1'b1, 2'b00, 64'd5, 1'b0, 1'b0, 1'b0);
    #1 checkOutput("t2_rdy5", 64'(bus.in_ready), 64'd1);
    step();
    checkOutput("t2_y0_5", bus.y0, 64'd5);
    applyStimulus(1'b1, 2'b00, 64'd6, 1'b0, 1'b0, 1'b0);
    #1 checkOutput("t2_rdy6_stall", 64'(bus.in_ready), 64'd0);
    step();
    checkOutput("t2_y0_hold", bus.y0, 64'd5);
    checkOutput("t2_v0_hold", 64'(bus.y0_valid), 64'd1);
    applyStimulus(1'b1, 2'b00, 64'd6, 1'b1, 1'b0, 1'b0);
    #1 checkOutput("t2_rdy6_go", 64'(bus.in_ready), 64'd1);
    step();
    checkOutput("t2_y0_6", bus.y0, 64'd6);
    checkValids("t2_fill6", 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'b00, 64'd0, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("t2_v0_drain", 64'(bus.y0_valid), 64'd0);

    // Full-throughput stream to ch2.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 2'b10, 64'(i), 1'b0, 1'b0, 1'b1);
      #1 checkOutput($sformatf("t3_rdy%0d", i), 64'(bus.in_ready), 64'd1);
      step();
      checkOutput($sformatf("t3_y2_%0d", i), bus.y2, 64'(i));
      checkOutput($sformatf("t3_v2_%0d", i), 64'(bus.y2_valid), 64'd1);
    end
    applyStimulus(1'b0, 2'b00, 64'd0, 1'b0, 1'b0, 1'b1);
    step();
    checkValids("t3_end", 1'b0, 1'b0, 1'b0);

    // Stalled ch0 must not block ch1.
    applyStimulus(1'b1, 2'b00, 64'd7, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 2'b01, 64'd9, 1'b0, 1'b0, 1'b0);
    #1 checkOutput("t4_rdy9", 64'(bus.in_ready), 64'd1);
    step();
    checkOutput("t4_y1", bus.y1, 64'd9);
    checkOutput("t4_y0", bus.y0, 64'd7);
    checkValids("t4", 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 2'b00, 64'd0, 1'b1, 1'b1, 1'b1);
    step();
    checkValids("t4_drain", 1'b0, 1'b0, 1'b0);

    // Invalid select, back to back, then idle.
    applyStimulus(1'b1, 2'b11, 64'hDEAD, 1'b0, 1'b0, 1'b0);
    #1 checkOutput("t5_rdy", 64'(bus.in_ready), 64'd1);
    checkOutput("t5_err_pre", 64'(bus.sel_err), 64'd0);
    step();
    checkOutput("t5_err1", 64'(bus.sel_err), 64'd1);
    checkValids("t5", 1'b0, 1'b0, 1'b0);
`ifdef DEMUX3_ERR_CNT_EN
    checkOutput("t5_cnt1", 64'(bus.err_cnt), 64'd1);
`endif
    step();
    checkOutput("t5_err2", 64'(bus.sel_err), 64'd1);
`ifdef DEMUX3_ERR_CNT_EN
    checkOutput("t5_cnt2", 64'(bus.err_cnt), 64'd2);
`endif
    applyStimulus(1'b0, 2'b11, 64'hDEAD, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("t5_err_off", 64'(bus.sel_err), 64'd0);
    checkOutput("t5_y0_untouched", bus.y0, 64'd7);

    // Fill every channel, then reset discards everything.
    applyStimulus(1'b1, 2'b00, 64'd3, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 2'b01, 64'd4, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 2'b10, 64'd8, 1'b0, 1'b0, 1'b0);
    step();
    checkValids("t6_full", 1'b1, 1'b1, 1'b1);
    checkOutput("t6_y0", bus.y0, 64'd3);
    checkOutput("t6_y1", bus.y1, 64'd4);
    checkOutput("t6_y2", bus.y2, 64'd8);
    reset = 1'b1;
    applyStimulus(1'b1, 2'b11, 64'hBEEF, 1'b1, 1'b1, 1'b1);
    step();
    reset = 1'b0;
    applyStimulus(1'b0, 2'b00, 64'd0, 1'b0, 1'b0, 1'b0);
    checkValids("t6_rst", 1'b0, 1'b0, 1'b0);
    checkOutput("t6_rst_y0", bus.y0, 64'd0);
    checkOutput("t6_rst_y1", bus.y1, 64'd0);
    checkOutput("t6_rst_y2", bus.y2, 64'd0);
    checkOutput("t6_rst_err", 64'(bus.sel_err), 64'd0);
`ifdef DEMUX3_ERR_CNT_EN
    checkOutput("t6_rst_cnt", 64'(bus.err_cnt), 64'd0);
`endif
    step();
    checkOutput("t6_post_err", 64'(bus.sel_err), 64'd0);
    checkValids("t6_post", 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux3_64bit_reg.md
Name: demux3_64bit_reg

Overview:
- Registered 1-to-3 result router for the factorial datapath; the distributing counterpart of the 3-input operand select.
- Takes one WIDTH-bit result with a 2-bit destination select. Delivers it to one of three output channels, each with its own valid/ready handshake.
- Each channel holds a one-entry buffer, so a stalled consumer blocks only its own channel.
- Sits between the multiplier/accumulator output and the consumers: register write-back, next-operand feedback, and final-result port.

Parameters:
- WIDTH, 64, data width of input and each output channel.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  result word to route.
- in_sel  input  2  destination: 00 -> ch0, 01 -> ch1, 10 -> ch2, 11 -> invalid.
- in_valid  input  1  in_data/in_sel valid this cycle.
- in_ready  output  1  block accepts the input this cycle.
- y0, y1, y2  output  WIDTH each  channel 0/1/2 buffered data.
- y0_valid, y1_valid, y2_valid  output  1 each  channel k holds valid data.
- y0_ready, y1_ready, y2_ready  input  1 each  consumer k takes data this cycle.
- sel_err  output  1  one-cycle pulse: an input with in_sel=11 was accepted and dropped.

Behaviour:
- Reset (synchronous, active-high; sampled on the clk rising edge):
  - All yk_valid = 0, all yk = 0, sel_err = 0.
  - Reset during operation discards all buffered words.
  - in_ready may be driven during reset, but no transfer is committed on a reset cycle.
- Handshakes:
  - Input transfer (accept) = in_valid & in_ready.
  - Channel k drain = yk_valid & yk_ready.
- in_ready (combinational):
  - in_sel=11: in_ready = 1.
  - Otherwise: in_ready = !yk_valid | yk_ready for the selected k.
  - This creates a combinational path from yk_ready to in_ready; this path is allowed and documented.
  - in_ready ignores in_valid.
- Accept to channel k:
  - yk <= in_data and yk_valid <= 1 at the next edge.
  - Latency is 1 cycle from accept to yk_valid.
- Drain of k with no fill of k in the same cycle: yk_valid <= 0; yk keeps its last value.
- Simultaneous drain and fill of k: yk_valid stays 1 and yk takes the new word.
  - This gives full throughput: one word per cycle per channel while the consumer is ready.
- Hold rule: while yk_valid & !yk_ready, yk and yk_valid are stable.
  - A new input for channel k stalls, with in_ready = 0.
- Channel independence: an accept to channel j never modifies channel k≠j.
  - All three channels may drain in the same cycle.
- Invalid select:
  - An accept with in_sel=11 writes no channel.
  - sel_err = 1 for exactly the next cycle, otherwise 0.
  - Back-to-back invalid accepts give sel_err high on consecutive cycles.
- When in_valid = 0: in_sel and in_data are don't-care, no state changes except drains, and sel_err = 0 next cycle.
- Ordering: words to the same channel are delivered in acceptance order. There is no ordering guarantee across channels.

Optional Feature:
- Macro: DEMUX3_ERR_CNT_EN.
- When defined:
  - Adds output err_cnt, 16 bits, reset 0.
  - err_cnt increments on every accept with in_sel=11.
  - It saturates at 16'hFFFF with no wrap.
  - It updates on the same edge that sets sel_err.
- When undefined:
  - The err_cnt port and counter do not exist.
  - sel_err behaviour is unchanged.

Test Plan:
- Reset, then in_data=64'd120, in_sel=01, in_valid=1 for 1 cycle, y1_ready=1 -> next cycle y1=120, y1_valid=1; the following cycle y1_valid=0; y0_valid and y2_valid stay 0.
- y0_ready=0; send 5 then 6 to ch0 -> 5 accepted; in_ready=0 while 6 is presented; y0 holds 5. Raise y0_ready -> 6 is accepted in the same cycle 5 drains; next cycle y0=6, y0_valid=1.
- Stream 1,2,3,4 to ch2 on consecutive cycles with y2_ready=1 -> in_ready stays 1; y2 shows 1,2,3,4 on consecutive cycles one cycle later.
- Stall ch0 holding 7 (y0_ready=0); send 9 to ch1 -> accepted immediately; y1=9 valid next cycle; y0=7 unchanged.
- in_sel=11 with in_data=64'hDEAD, in_valid=1 -> in_ready=1; sel_err=1 for one cycle; no yk_valid rises; with DEMUX3_ERR_CNT_EN, err_cnt goes 0 -> 1.
- Fill ch0=3, ch1=4, ch2=8 with all readies 0, then assert reset for 1 cycle -> all yk_valid=0, all yk=0, sel_err=0; err_cnt=0 if present.
